// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between instruction fetch and IEU data
// accesses, issuing one bus transaction at a time with timeout-based abort.
module mem_port_arbiter #(
  parameter int TIMEOUT     = 64,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFReq,
  input  logic [31:0] IFAdr,
  output logic        IFDone,
  output logic [31:0] IFRData,
  input  logic        DReq,
  input  logic [31:0] DAdr,
  input  logic [3:0]  DWriteByteEn,
  input  logic [31:0] DWriteData,
  output logic        DDone,
  output logic [31:0] DReadData,
  output logic        BusReq,
  output logic [31:0] BusAdr,
  output logic [3:0]  BusWriteByteEn,
  output logic [31:0] BusWriteData,
  input  logic        BusAck,
  input  logic [31:0] BusRData,
  output logic        BusErr,
  output logic        Stall
);

  localparam int TW = 8;
  localparam int SW = $clog2(DATA_STREAK + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic [31:0]   bus_adr_q, bus_adr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic arb_en;
  logic win_data;
  logic win_fetch;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + SW'(1);
  endfunction

  // The IDLE cycle carrying a Done pulse is not arbitrated, so a requester
  // still holding its just-served request is not granted a second time.
  assign arb_en    = (state_q == IDLE) && !if_done_q && !d_done_q;
  assign win_data  = arb_en && DReq && (!IFReq || (streak_q < STREAK_MAX));
  assign win_fetch = arb_en && IFReq && !win_data;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_adr_d   = bus_adr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    bus_err_d   = 1'b0;
    tmo_d       = tmo_q;
    streak_d    = streak_q;

    case (state_q)
      IDLE: begin
        if (win_data) begin
          state_d     = DATA;
          bus_req_d   = 1'b1;
          bus_adr_d   = DAdr;
          bus_be_d    = DWriteByteEn;
          bus_wdata_d = DWriteData;
          tmo_d       = '0;
        end else if (win_fetch) begin
          state_d     = FETCH;
          bus_req_d   = 1'b1;
          bus_adr_d   = IFAdr;
          bus_be_d    = 4'b0000;
          bus_wdata_d = 32'h0;
          tmo_d       = '0;
        end
      end
      FETCH, DATA: begin
        if (BusAck) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          tmo_d     = '0;
          if (state_q == FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = BusRData;
          end else begin
            d_done_d = 1'b1;
            if (bus_be_q == 4'b0000) d_rdata_d = BusRData;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort: report the error and release the requester with zero data.
          state_d   = IDLE;
          bus_req_d = 1'b0;
          tmo_d     = '0;
          bus_err_d = 1'b1;
          if (state_q == FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = 32'h0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = 32'h0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!IFReq)         streak_d = '0;
    else if (win_fetch) streak_d = '0;
    else if (win_data)  streak_d = streak_inc(streak_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_adr_q   <= 32'h0;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_adr_q   <= bus_adr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  assign BusReq         = bus_req_q;
  assign BusAdr         = bus_adr_q;
  assign BusWriteByteEn = bus_be_q;
  assign BusWriteData   = bus_wdata_q;
  assign IFDone         = if_done_q;
  assign DDone          = d_done_q;
  assign BusErr         = bus_err_q;
  assign IFRData        = if_rdata_q;
  assign DReadData      = d_rdata_q;
  assign Stall          = (IFReq & ~if_done_q) | (DReq & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a bus responder model acks after a set
// delay and every Done pulse is matched against the expected transaction queue.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IFReq;
  logic [31:0] IFAdr;
  logic        IFDone;
  logic [31:0] IFRData;
  logic        DReq;
  logic [31:0] DAdr;
  logic [3:0]  DWriteByteEn;
  logic [31:0] DWriteData;
  logic        DDone;
  logic [31:0] DReadData;
  logic        BusReq;
  logic [31:0] BusAdr;
  logic [3:0]  BusWriteByteEn;
  logic [31:0] BusWriteData;
  logic        BusAck;
  logic [31:0] BusRData;
  logic        BusErr;
  logic        Stall;

  mem_port_arbiter #(.TIMEOUT(64), .DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .IFReq(IFReq), .IFAdr(IFAdr), .IFDone(IFDone), .IFRData(IFRData),
    .DReq(DReq), .DAdr(DAdr), .DWriteByteEn(DWriteByteEn), .DWriteData(DWriteData),
    .DDone(DDone), .DReadData(DReadData),
    .BusReq(BusReq), .BusAdr(BusAdr), .BusWriteByteEn(BusWriteByteEn),
    .BusWriteData(BusWriteData), .BusAck(BusAck), .BusRData(BusRData),
    .BusErr(BusErr), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fetch;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ack_delay = 0;
  bit   ack_en = 1'b1;
  int   wait_cnt = 0;
  logic [31:0] d_model = 32'h0;
  logic [31:0] i_model = 32'h0;

  function automatic exp_t mk(input bit f, input logic [31:0] d, input bit er);
    exp_t e;
    e.is_fetch = f;
    e.rdata    = d;
    e.err      = er;
    return e;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0010_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Advance one clock, then play the memory: ack ack_delay cycles after BusReq.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (BusReq && ack_en) begin
      if (wait_cnt == ack_delay) begin
        BusAck   = 1'b1;
        BusRData = mem_word(BusAdr);
        wait_cnt = 0;
      end else begin
        BusAck = 1'b0;
        wait_cnt++;
      end
    end else begin
      BusAck   = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    tests++;
    if (BusReq !== 1'b0 || IFDone !== 1'b0 || DDone !== 1'b0 || BusErr !== 1'b0 || Stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got req=%b ifd=%b dd=%b err=%b stall=%b exp all 0",
               BusReq, IFDone, DDone, BusErr, Stall);
    end
    tests++;
    if (BusAdr !== 32'h0 || BusWriteByteEn !== 4'h0 || BusWriteData !== 32'h0 ||
        IFRData !== 32'h0 || DReadData !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got adr=%h be=%h wd=%h ifr=%h dr=%h exp all 0",
               BusAdr, BusWriteByteEn, BusWriteData, IFRData, DReadData);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    exp_t e;
    int ndone = 0;
    int rise = 0;
    ack_delay = 2;
    IFReq = 1'b1;
    IFAdr = 32'h0000_0100;
    sb.push_back(mk(1'b1, 32'h0010_0093, 1'b0));
    i_model = 32'h0010_0093;
    #1;
    tests++;
    if (Stall !== 1'b1) begin fails++; $display("FAIL fetch_stall got=%b exp=1", Stall); end
    step();
    rise = cyc;
    tests++;
    if (BusReq !== 1'b1 || BusAdr !== 32'h100 || BusWriteByteEn !== 4'h0) begin
      fails++;
      $display("FAIL fetch_grant got req=%b adr=%h be=%h exp 1/100/0", BusReq, BusAdr, BusWriteByteEn);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (IFDone) begin
        ndone++;
        if (ndone == 1 && sb.size() > 0) begin
          e = sb.pop_front();
          tests++;
          if (!e.is_fetch || IFRData !== e.rdata || BusErr !== e.err || (cyc - rise) != 3) begin
            fails++;
            $display("FAIL fetch_done got data=%h err=%b lat=%0d exp %h/%b/3",
                     IFRData, BusErr, cyc - rise, e.rdata, e.err);
          end
          IFReq = 1'b0;
        end
      end
    end
    tests++;
    if (ndone != 1) begin fails++; $display("FAIL fetch_done_count got=%0d exp=1", ndone); end
  endtask

  task automatic test_load();
    exp_t e;
    bit got = 1'b0;
    ack_delay = 0;
    DReq = 1'b1; DAdr = 32'h0000_3000; DWriteByteEn = 4'h0; DWriteData = 32'h1111_1111;
    sb.push_back(mk(1'b0, mem_word(32'h3000), 1'b0));
    d_model = mem_word(32'h3000);
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (DDone) begin
        got = 1'b1;
        e = sb.pop_front();
        tests++;
        if (e.is_fetch || DReadData !== e.rdata || IFDone !== 1'b0) begin
          fails++;
          $display("FAIL load_done got data=%h ifd=%b exp %h/0", DReadData, IFDone, e.rdata);
        end
        DReq = 1'b0;
      end
    end
    if (!got) begin tests++; fails++; $display("FAIL load_timeout got=none exp=DDone"); end
    step();
  endtask

  task automatic test_store();
    exp_t e;
    bit got = 1'b0;
    ack_delay = 1;
    DReq = 1'b1; DAdr = 32'h0000_2004; DWriteByteEn = 4'b0011; DWriteData = 32'hDEAD_BEEF;
    sb.push_back(mk(1'b0, d_model, 1'b0));
    step();
    tests++;
    if (BusReq !== 1'b1 || BusAdr !== 32'h2004 || BusWriteByteEn !== 4'b0011 ||
        BusWriteData !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL store_bus got req=%b adr=%h be=%b wd=%h exp 1/2004/0011/deadbeef",
               BusReq, BusAdr, BusWriteByteEn, BusWriteData);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (BusAck) begin
        tests++;
        if (BusAdr !== 32'h2004 || BusWriteData !== 32'hDEAD_BEEF) begin
          fails++;
          $display("FAIL store_hold got adr=%h wd=%h exp 2004/deadbeef", BusAdr, BusWriteData);
        end
      end
      if (DDone) begin
        got = 1'b1;
        e = sb.pop_front();
        tests++;
        if (DReadData !== e.rdata) begin
          fails++;
          $display("FAIL store_rdata got=%h exp=%h", DReadData, e.rdata);
        end
        DReq = 1'b0;
      end
    end
    if (!got) begin tests++; fails++; $display("FAIL store_timeout got=none exp=DDone"); end
    step();
  endtask

  task automatic test_contention();
    exp_t e;
    int n = 0;
    ack_delay = 0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back(mk(1'b0, mem_word(32'h500), 1'b0));
      sb.push_back(mk(1'b1, mem_word(32'h400), 1'b0));
    end
    IFReq = 1'b1; IFAdr = 32'h0000_0400;
    DReq = 1'b1; DAdr = 32'h0000_0500; DWriteByteEn = 4'h0; DWriteData = 32'h0;
    for (int i = 0; i < 120 && n < 10; i++) begin
      step();
      if (IFDone || DDone) begin
        n++;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL cont_extra got done#%0d exp none", n);
        end else begin
          e = sb.pop_front();
          tests++;
          if (IFDone !== e.is_fetch || DDone !== ~e.is_fetch ||
              (e.is_fetch ? IFRData : DReadData) !== e.rdata) begin
            fails++;
            $display("FAIL cont_order#%0d got ifd=%b dd=%b ifr=%h dr=%h exp fetch=%b data=%h",
                     n, IFDone, DDone, IFRData, DReadData, e.is_fetch, e.rdata);
          end
        end
        if (n == 10) begin IFReq = 1'b0; DReq = 1'b0; end
      end
    end
    d_model = mem_word(32'h500);
    i_model = mem_word(32'h400);
    tests++;
    if (n != 10) begin fails++; $display("FAIL cont_count got=%0d exp=10", n); end
    sb.delete();
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n = 0;
    int last = 0;
    ack_delay = 0;
    for (int k = 0; k < 3; k++) sb.push_back(mk(1'b1, mem_word(32'h1000 + 32'(4 * k)), 1'b0));
    IFReq = 1'b1; IFAdr = 32'h0000_1000;
    for (int i = 0; i < 40 && n < 3; i++) begin
      step();
      if (IFDone) begin
        e = sb.pop_front();
        tests++;
        if (IFRData !== e.rdata || (n > 0 && (cyc - last) != 3)) begin
          fails++;
          $display("FAIL b2b#%0d got data=%h gap=%0d exp %h/3", n, IFRData, cyc - last, e.rdata);
        end
        last = cyc;
        n++;
        IFAdr = IFAdr + 32'h4;
        if (n == 3) IFReq = 1'b0;
      end
    end
    i_model = mem_word(32'h1008);
    tests++;
    if (n != 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", n); end
    step();
  endtask

  task automatic test_stray_ack();
    BusAck = 1'b1;
    BusRData = 32'hFFFF_FFFF;
    step();
    tests++;
    if (IFDone !== 1'b0 || DDone !== 1'b0 || BusReq !== 1'b0) begin
      fails++;
      $display("FAIL stray_done got ifd=%b dd=%b req=%b exp 0/0/0", IFDone, DDone, BusReq);
    end
    step();
    tests++;
    if (IFRData !== i_model || DReadData !== d_model || IFDone !== 1'b0 || DDone !== 1'b0) begin
      fails++;
      $display("FAIL stray_data got ifr=%h dr=%h exp %h/%h", IFRData, DReadData, i_model, d_model);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit got = 1'b0;
    int rise = 0;
    int errs_early = 0;
    ack_en = 1'b0;
    DReq = 1'b1; DAdr = 32'h0000_0600; DWriteByteEn = 4'h0; DWriteData = 32'h0;
    sb.push_back(mk(1'b0, 32'h0, 1'b1));
    step();
    rise = cyc;
    tests++;
    if (BusReq !== 1'b1) begin fails++; $display("FAIL tmo_req got=%b exp=1", BusReq); end
    for (int i = 0; i < 100 && !got; i++) begin
      step();
      if (DDone) begin
        got = 1'b1;
        e = sb.pop_front();
        tests++;
        if (BusErr !== e.err || DReadData !== e.rdata || (cyc - rise) != 64 ||
            BusReq !== 1'b0 || Stall !== 1'b0) begin
          fails++;
          $display("FAIL tmo_done got err=%b dr=%h dt=%0d req=%b stall=%b exp 1/0/64/0/0",
                   BusErr, DReadData, cyc - rise, BusReq, Stall);
        end
        DReq = 1'b0;
      end else if (BusErr) begin
        errs_early++;
      end
    end
    d_model = 32'h0;
    if (!got) begin tests++; fails++; $display("FAIL tmo_wait got=none exp=DDone"); end
    step();
    tests++;
    if (BusErr !== 1'b0 || DDone !== 1'b0 || errs_early != 0) begin
      fails++;
      $display("FAIL tmo_pulse got err=%b dd=%b early=%0d exp 0/0/0", BusErr, DDone, errs_early);
    end
    step();
    tests++;
    if (BusReq !== 1'b0) begin fails++; $display("FAIL tmo_idle got req=%b exp=0", BusReq); end
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit got = 1'b0;
    int bad = 0;
    ack_en = 1'b0;
    IFReq = 1'b1; IFAdr = 32'h0000_0700;
    step();
    step();
    tests++;
    if (BusReq !== 1'b1) begin fails++; $display("FAIL rst_mid_pre got req=%b exp=1", BusReq); end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (BusReq !== 1'b0 || IFDone !== 1'b0 || BusErr !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async got req=%b ifd=%b err=%b exp 0/0/0", BusReq, IFDone, BusErr);
    end
    IFReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset = 1'b1;
      step();
      if (IFDone !== 1'b0 || BusReq !== 1'b0 || BusErr !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rst_mid_quiet got bad=%0d exp=0", bad); end
    i_model = 32'h0;
    d_model = 32'h0;
    ack_en = 1'b1;
    ack_delay = 1;
    IFReq = 1'b1; IFAdr = 32'h0000_0800;
    sb.push_back(mk(1'b1, mem_word(32'h800), 1'b0));
    step();
    tests++;
    if (BusReq !== 1'b1 || BusAdr !== 32'h800) begin
      fails++;
      $display("FAIL rst_mid_regrant got req=%b adr=%h exp 1/800", BusReq, BusAdr);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (IFDone) begin
        got = 1'b1;
        e = sb.pop_front();
        tests++;
        if (IFRData !== e.rdata) begin
          fails++;
          $display("FAIL rst_mid_data got=%h exp=%h", IFRData, e.rdata);
        end
        IFReq = 1'b0;
      end
    end
    if (!got) begin tests++; fails++; $display("FAIL rst_mid_wait got=none exp=IFDone"); end
    step();
  endtask

  initial begin
    reset = 1'b0;
    IFReq = 1'b0; IFAdr = 32'h0;
    DReq = 1'b0; DAdr = 32'h0; DWriteByteEn = 4'h0; DWriteData = 32'h0;
    BusAck = 1'b0; BusRData = 32'h0;
    test_reset();
    test_single_fetch();
    test_load();
    test_store();
    test_contention();
    test_back_to_back();
    test_stray_ack();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between the instruction-fetch requester and the IEU load/store requester.
- Sits between the PC/fetch logic, the IEU data interface and the external memory bus.
- Issues one bus transaction at a time. Holds each request stable until the memory acknowledges it.
- Returns read data and completion pulses to the requester that was served, and raises a stall while any request is pending.

Parameters:
- TIMEOUT, 64, max cycles a bus transaction may wait for BusAck before it is aborted with an error; legal range 2..255.
- DATA_STREAK, 4, max consecutive data grants while a fetch is pending before fetch is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IFReq  in  1  fetch request, level; held until IFDone.
- IFAdr  in  32  fetch address, word-aligned; stable while IFReq.
- IFDone  out  1  one-cycle pulse: fetch complete, IFRData valid.
- IFRData  out  32  fetched instruction; held until next IFDone.
- DReq  in  1  data request (IEU MemEn), level; held until DDone.
- DAdr  in  32  data address (IEUAdr).
- DWriteByteEn  in  4  byte enables; 0 = load, nonzero = store.
- DWriteData  in  32  store data.
- DDone  out  1  one-cycle pulse: data access complete.
- DReadData  out  32  load data; held until next DDone.
- BusReq  out  1  bus request, held until BusAck or timeout.
- BusAdr  out  32  bus address.
- BusWriteByteEn  out  4  bus byte enables.
- BusWriteData  out  32  bus write data.
- BusAck  in  1  memory completion, one cycle; BusRData valid the same cycle.
- BusRData  in  32  memory read data.
- BusErr  out  1  one-cycle pulse: transaction timed out.
- Stall  out  1  high while any IFReq/DReq is pending without its Done.

Behaviour:
- Reset (reset low, asynchronous):
  - FSM to IDLE.
  - BusReq, IFDone, DDone and BusErr go to 0.
  - BusAdr, BusWriteByteEn, BusWriteData, IFRData and DReadData go to 0.
  - Streak counter and timeout counter go to 0.
  - Reset asserted mid-transaction abandons it with no Done and no BusErr.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - If DReq and (no IFReq or streak < DATA_STREAK): go to DATA.
  - Else if IFReq: go to FETCH.
  - Else stay in IDLE.
  - On entering a state, BusReq=1 and the Bus* fields are registered from the winning requester on the same edge.
  - Request-to-BusReq latency is 1 cycle.
- FETCH / DATA:
  - Bus* outputs are held constant.
  - The timeout counter increments each cycle BusAck=0.
  - On BusAck:
    - BusReq drops on the next edge.
    - The matching Done pulses one cycle after BusAck.
    - BusRData is captured into IFRData, or into DReadData for loads only; stores leave DReadData unchanged.
    - FSM returns to IDLE.
  - On counter reaching TIMEOUT-1 without ack:
    - BusErr pulses.
    - The matching Done also pulses, with read data 0.
    - BusReq drops and the FSM goes to IDLE.
- Back-to-back: the minimum transaction is 3 cycles (IDLE, state, ack cycle). The IDLE cycle after completion lets the requester drop or update its request before re-arbitration.
- Streak counter:
  - Increments on each data grant made while IFReq=1, saturating at DATA_STREAK.
  - Clears on any fetch grant, or whenever IFReq=0.
- Simultaneous IFReq and DReq in IDLE: data wins unless streak = DATA_STREAK.
- A requester dropping its request mid-transaction is a protocol error. The transaction completes anyway and Done still pulses.
- BusAck in IDLE is ignored.
- Stall = (IFReq & ~IFDone) | (DReq & ~DDone), combinational.

Test Plan:
- Single fetch:
  - Stimulus: IFReq=1, IFAdr=0x0000_0100; BusAck arrives 2 cycles after BusReq with BusRData=0x0010_0093.
  - Response: BusAdr=0x100, BusWriteByteEn=0; IFDone pulses once; IFRData=0x0010_0093.
- Store:
  - Stimulus: DReq=1, DAdr=0x2004, DWriteByteEn=4'b0011, DWriteData=0xDEAD_BEEF.
  - Response: bus fields match; DDone pulses; DReadData unchanged.
- Contention:
  - Stimulus: IFReq and DReq asserted in the same cycle.
  - Response: DATA is served first and DDone precedes IFDone. With DReq held continuously, a fetch grant occurs after exactly 4 data grants.
- Timeout:
  - Stimulus: DReq asserted, BusAck never arrives.
  - Response: BusErr and DDone pulse together 64 cycles after BusReq rises; DReadData=0; FSM back in IDLE.
- Reset mid-transaction:
  - Stimulus: drop reset while in FETCH.
  - Response: BusReq=0 immediately, with no IFDone pulse. After release, a new request sees a 1-cycle grant latency.
- Stray BusAck:
  - Stimulus: BusAck pulsed in IDLE.
  - Response: no Done pulse and no state change.
